reg_file_param: RTL and testbench



---
 rtl/reg_file_pkg.sv | 27 ++
 rtl/reg_file_if.sv | 30 +++
 rtl/reg_file_rd_pipe.sv | 53 +++++
 rtl/reg_file_param.sv | 109 ++++++++++
 tb/tb_reg_file_param.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_file_pkg.sv
// Shared defaults for the parametrised configuration register file: widths,
// UART power-up configuration values and the default reset-value vector builder.
package reg_file_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADD_W_DEF  = 4;

  localparam logic [7:0] CFG_UART_DEFAULT = 8'h81;
  localparam logic [7:0] CFG_DIV_DEFAULT  = 8'h20;

  // Wide enough for any practical DEPTH*DATA_W; callers cast down to their size.
  localparam int RST_VALS_MAX_W = 4096;

  function automatic logic [RST_VALS_MAX_W-1:0] default_rst_vals(input int depth, input int data_w);
    logic [RST_VALS_MAX_W-1:0] v;
    logic [7:0]                val;
    v = '0;
    for (int i = 0; i < depth; i++) begin
      val = (i == 2) ? CFG_UART_DEFAULT : (i == 3) ? CFG_DIV_DEFAULT : 8'h00;
      for (int b = 0; b < data_w; b++) begin
        if (b < 8 && (i * data_w + b) < RST_VALS_MAX_W) v[i*data_w+b] = val[b];
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/reg_file_if.sv
// Controller-side bus of the configuration register file.
interface reg_file_if
  import reg_file_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADD_W  = ADD_W_DEF
);
    // WrEn/RdEn are single-cycle request strobes with no back-pressure: every
    // strobe is consumed at the edge it is sampled, and a read answers with a
    // one-cycle RdData_Valid pulse a fixed RD_LAT cycles later.
    logic              WrEn;
    logic              RdEn;
    logic [ADD_W-1:0]  Address;
    logic [DATA_W-1:0] WrData;
    logic              Commit;
    logic [DATA_W-1:0] RdData;
    logic              RdData_Valid;
    logic              Err;

    modport master (
        output WrEn, RdEn, Address, WrData, Commit,
        input  RdData, RdData_Valid, Err
    );

    modport slave (
        input  WrEn, RdEn, Address, WrData, Commit,
        output RdData, RdData_Valid, Err
    );

endinterface

// File: rtl/reg_file_rd_pipe.sv
// Read-return pipeline: carries data/valid/err through RD_LAT (1 or 2) stages;
// the final data register holds its value between valid reads.
module reg_file_rd_pipe #(
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              Clk,
    input  logic              RST,
    input  logic              in_valid,
    input  logic              in_err,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic              out_err,
    output logic [DATA_W-1:0] out_data
);

    logic              s_valid;
    logic              s_err;
    logic [DATA_W-1:0] s_data;

    generate
        if (RD_LAT == 2) begin : g_stage
            always_ff @(posedge Clk or posedge RST) begin
                if (RST) begin
                    s_valid <= 1'b0;
                    s_err   <= 1'b0;
                    s_data  <= '0;
                end else begin
                    s_valid <= in_valid;
                    s_err   <= in_err;
                    s_data  <= in_data;
                end
            end
        end else begin : g_bypass
            assign s_valid = in_valid;
            assign s_err   = in_err;
            assign s_data  = in_data;
        end
    endgenerate

    always_ff @(posedge Clk or posedge RST) begin
        if (RST) begin
            out_valid <= 1'b0;
            out_err   <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= s_valid;
            out_err   <= s_err;
            if (s_valid) out_data <= s_data;
        end
    end

endmodule

// File: rtl/reg_file_param.sv
// Parametrised UART configuration register file with read-only mask and error pulses.
// Define REG_FILE_SHADOW_EN to drive RegOut from a Commit-updated shadow bank.
module reg_file_param
  import reg_file_pkg::*;
#(
    parameter int                       DATA_W     = DATA_W_DEF,
    parameter int                       ADD_W      = ADD_W_DEF,
    parameter int                       DEPTH      = 16,
    parameter int                       NUM_EXPORT = 4,
    parameter logic [DEPTH*DATA_W-1:0]  RST_VALS   = (DEPTH*DATA_W)'(default_rst_vals(DEPTH, DATA_W)),
    parameter logic [DEPTH-1:0]         RO_MASK    = '0,
    parameter int                       RD_LAT     = 1
) (
    input  logic                         Clk,
    input  logic                         RST,
    reg_file_if.slave                    bus,
    output logic [NUM_EXPORT*DATA_W-1:0] RegOut
);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              addr_ok;
    logic              ro_hit;
    logic              wr_req;
    logic              rd_req;
    logic              both_req;
    logic              wr_ok;
    logic              wr_err;
    logic              rd_err;
    logic              wr_err_q;
    logic              pipe_err;
    logic [DATA_W-1:0] rd_word;

    // Address match by loop so an out-of-range address simply selects nothing.
    always_comb begin
        addr_ok  = 32'(bus.Address) < 32'(DEPTH);
        ro_hit   = 1'b0;
        rd_word  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.Address == ADD_W'(i)) begin
                ro_hit  = RO_MASK[i];
                rd_word = mem[i];
            end
        end
        wr_req   = bus.WrEn & ~bus.RdEn;
        rd_req   = bus.RdEn & ~bus.WrEn;
        both_req = bus.WrEn & bus.RdEn;
        wr_ok    = wr_req & addr_ok & ~ro_hit;
        wr_err   = both_req | (wr_req & ~(addr_ok & ~ro_hit));
        rd_err   = rd_req & ~addr_ok;
    end

    always_ff @(posedge Clk or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= RST_VALS[i*DATA_W +: DATA_W];
            wr_err_q <= 1'b0;
        end else begin
            wr_err_q <= wr_err;
            if (wr_ok) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (bus.Address == ADD_W'(i)) mem[i] <= bus.WrData;
                end
            end
        end
    end

    reg_file_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .Clk       (Clk),
        .RST       (RST),
        .in_valid  (rd_req),
        .in_err    (rd_err),
        .in_data   (rd_word),
        .out_valid (bus.RdData_Valid),
        .out_err   (pipe_err),
        .out_data  (bus.RdData)
    );

    // Write errors surface one edge after the request, read errors with their
    // Valid; with RD_LAT=2 the two can coincide and are merged.
    assign bus.Err = wr_err_q | pipe_err;

`ifdef REG_FILE_SHADOW_EN
    logic [DATA_W-1:0] shadow [NUM_EXPORT];

    // Non-blocking copy captures mem as it was before this edge's write.
    always_ff @(posedge Clk or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NUM_EXPORT; i++) shadow[i] <= RST_VALS[i*DATA_W +: DATA_W];
        end else if (bus.Commit) begin
            for (int i = 0; i < NUM_EXPORT; i++) shadow[i] <= mem[i];
        end
    end

    for (genvar g = 0; g < NUM_EXPORT; g++) begin : g_export
        assign RegOut[g*DATA_W +: DATA_W] = shadow[g];
    end
`else
    logic unused_commit;
    assign unused_commit = bus.Commit;

    for (genvar g = 0; g < NUM_EXPORT; g++) begin : g_export
        assign RegOut[g*DATA_W +: DATA_W] = mem[g];
    end
`endif

endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: two instances (RD_LAT=1/DEPTH=12/reg3 read-only and
// RD_LAT=2/DEPTH=16) share one stimulus stream and are checked against a model.
module tb_reg_file_param;

  localparam int DW   = 8;
  localparam int AW   = 4;
  localparam int NX   = 4;
  localparam int MAXC = 2048;

  logic Clk = 1'b0;
  logic RST;
  always #5 Clk = ~Clk;

  logic           we, re, cm;
  logic [AW-1:0]  addr;
  logic [DW-1:0]  wd;

  reg_file_if #(.DATA_W(DW), .ADD_W(AW)) if_a ();
  reg_file_if #(.DATA_W(DW), .ADD_W(AW)) if_b ();
  logic [NX*DW-1:0] regout_a, regout_b;

  assign if_a.WrEn = we;  assign if_a.RdEn = re;  assign if_a.Address = addr;
  assign if_a.WrData = wd; assign if_a.Commit = cm;
  assign if_b.WrEn = we;  assign if_b.RdEn = re;  assign if_b.Address = addr;
  assign if_b.WrData = wd; assign if_b.Commit = cm;

  reg_file_param #(
    .DATA_W(DW), .ADD_W(AW), .DEPTH(12), .NUM_EXPORT(NX),
    .RO_MASK(12'h008), .RD_LAT(1)
  ) u_a (
    .Clk(Clk), .RST(RST), .bus(if_a.slave), .RegOut(regout_a)
  );

  reg_file_param #(
    .DATA_W(DW), .ADD_W(AW), .DEPTH(16), .NUM_EXPORT(NX),
    .RO_MASK(16'h0000), .RD_LAT(2)
  ) u_b (
    .Clk(Clk), .RST(RST), .bus(if_b.slave), .RegOut(regout_b)
  );

  // Reference model: register contents, shadow, and per-cycle expected events.
  int         dep [2] = '{12, 16};
  int         lat [2] = '{1, 2};
  logic [15:0] rom [2] = '{16'h0008, 16'h0000};
  logic [7:0] m_mem [2][16];
  logic [7:0] m_sh  [2][NX];
  logic [7:0] m_rd  [2];
  bit         sch_v [2][MAXC];
  bit         sch_e [2][MAXC];
  logic [7:0] sch_d [2][MAXC];

  int cyc;
  int n_checks;
  int n_errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) m_mem[d][i] = (i == 2) ? 8'h81 : (i == 3) ? 8'h20 : 8'h00;
      for (int i = 0; i < NX; i++) m_sh[d][i] = m_mem[d][i];
      m_rd[d] = 8'h00;
      for (int c = 0; c < MAXC; c++) begin
        sch_v[d][c] = 1'b0;
        sch_e[d][c] = 1'b0;
        sch_d[d][c] = 8'h00;
      end
    end
  endtask

  task automatic model_edge();
    int t;
    for (int d = 0; d < 2; d++) begin
      if (cm) for (int i = 0; i < NX; i++) m_sh[d][i] = m_mem[d][i];
      if (we && re) begin
        sch_e[d][cyc] = 1'b1;
      end else if (we) begin
        if (int'(addr) < dep[d] && !rom[d][addr]) m_mem[d][addr] = wd;
        else sch_e[d][cyc] = 1'b1;
      end else if (re) begin
        t = cyc + lat[d] - 1;
        sch_v[d][t] = 1'b1;
        if (int'(addr) < dep[d]) sch_d[d][t] = m_mem[d][addr];
        else begin
          sch_d[d][t] = 8'h00;
          sch_e[d][t] = 1'b1;
        end
      end
    end
  endtask

  function automatic logic [NX*DW-1:0] exp_regout(input int d);
    logic [NX*DW-1:0] v;
    for (int i = 0; i < NX; i++) begin
`ifdef REG_FILE_SHADOW_EN
      v[i*DW +: DW] = m_sh[d][i];
`else
      v[i*DW +: DW] = m_mem[d][i];
`endif
    end
    return v;
  endfunction

  task automatic check_all();
    for (int d = 0; d < 2; d++) if (sch_v[d][cyc]) m_rd[d] = sch_d[d][cyc];
    chk("a_valid",  32'(if_a.RdData_Valid), 32'(sch_v[0][cyc]));
    chk("a_err",    32'(if_a.Err),          32'(sch_e[0][cyc]));
    chk("a_rddata", 32'(if_a.RdData),       32'(m_rd[0]));
    chk("a_regout", regout_a,               exp_regout(0));
    chk("b_valid",  32'(if_b.RdData_Valid), 32'(sch_v[1][cyc]));
    chk("b_err",    32'(if_b.Err),          32'(sch_e[1][cyc]));
    chk("b_rddata", 32'(if_b.RdData),       32'(m_rd[1]));
    chk("b_regout", regout_b,               exp_regout(1));
  endtask

  task automatic set_in(input logic w, input logic r, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic c);
    we = w; re = r; addr = a; wd = d; cm = c;
  endtask

  task automatic step();
    @(posedge Clk);
    cyc++;
    model_edge();
    @(negedge Clk);
    check_all();
  endtask

  // Asserted away from the clock edge; the async reset must clear outputs at once.
  task automatic do_reset(input int n);
    set_in(0, 0, '0, '0, 0);
    RST = 1'b1;
    model_reset();
    #1;
    chk("rst_valid_a", 32'(if_a.RdData_Valid), 32'd0);
    chk("rst_data_b",  32'(if_b.RdData),       32'd0);
    chk("rst_err_b",   32'(if_b.Err),          32'd0);
    repeat (n) begin
      @(posedge Clk);
      cyc++;
      @(negedge Clk);
      check_all();
    end
    RST = 1'b0;
  endtask

  typedef struct {
    logic          we, re;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          c;
    logic          ev, ee;
    logic [DW-1:0] ed, r0_plain, r0_shadow;
  } vec_t;

  function automatic vec_t mk(input logic w, input logic r, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input logic c, input logic ev,
                              input logic ee, input logic [DW-1:0] ed,
                              input logic [DW-1:0] r0p, input logic [DW-1:0] r0s);
    vec_t v;
    v.we = w; v.re = r; v.a = a; v.d = d; v.c = c;
    v.ev = ev; v.ee = ee; v.ed = ed; v.r0_plain = r0p; v.r0_shadow = r0s;
    return v;
  endfunction

  vec_t tbl [18];
  logic [7:0] bb_d [4];
  logic [7:0] rst_d [4];

  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    RST      = 1'b0;
    set_in(0, 0, '0, '0, 0);

    // Expected outputs of the RD_LAT=1, DEPTH=12, reg3-read-only instance after each edge.
    //             we re addr  wdata  cm  ev ee  data   r0 plain r0 shadow
    tbl[0]  = mk(0, 1, 4'd0,  8'h00, 0, 1, 0, 8'h00, 8'h00, 8'h00);
    tbl[1]  = mk(0, 1, 4'd1,  8'h00, 0, 1, 0, 8'h00, 8'h00, 8'h00);
    tbl[2]  = mk(0, 1, 4'd2,  8'h00, 0, 1, 0, 8'h81, 8'h00, 8'h00);
    tbl[3]  = mk(0, 1, 4'd3,  8'h00, 0, 1, 0, 8'h20, 8'h00, 8'h00);
    tbl[4]  = mk(0, 0, 4'd0,  8'h00, 0, 0, 0, 8'h20, 8'h00, 8'h00);
    tbl[5]  = mk(1, 0, 4'd5,  8'hA5, 0, 0, 0, 8'h20, 8'h00, 8'h00);
    tbl[6]  = mk(0, 1, 4'd5,  8'h00, 0, 1, 0, 8'hA5, 8'h00, 8'h00);
    tbl[7]  = mk(1, 0, 4'd3,  8'hFF, 0, 0, 1, 8'hA5, 8'h00, 8'h00);
    tbl[8]  = mk(0, 1, 4'd3,  8'h00, 0, 1, 0, 8'h20, 8'h00, 8'h00);
    tbl[9]  = mk(0, 1, 4'd14, 8'h00, 0, 1, 1, 8'h00, 8'h00, 8'h00);
    tbl[10] = mk(1, 0, 4'd13, 8'h77, 0, 0, 1, 8'h00, 8'h00, 8'h00);
    tbl[11] = mk(0, 1, 4'd13, 8'h00, 0, 1, 1, 8'h00, 8'h00, 8'h00);
    tbl[12] = mk(1, 1, 4'd1,  8'h55, 0, 0, 1, 8'h00, 8'h00, 8'h00);
    tbl[13] = mk(0, 1, 4'd1,  8'h00, 0, 1, 0, 8'h00, 8'h00, 8'h00);
    tbl[14] = mk(1, 0, 4'd0,  8'h11, 0, 0, 0, 8'h00, 8'h11, 8'h00);
    tbl[15] = mk(1, 0, 4'd0,  8'h22, 1, 0, 0, 8'h00, 8'h22, 8'h11);
    tbl[16] = mk(0, 0, 4'd0,  8'h00, 1, 0, 0, 8'h00, 8'h22, 8'h22);
    tbl[17] = mk(0, 1, 4'd0,  8'h00, 0, 1, 0, 8'h22, 8'h22, 8'h22);

    do_reset(2);

    for (int k = 0; k < 18; k++) begin
      set_in(tbl[k].we, tbl[k].re, tbl[k].a, tbl[k].d, tbl[k].c);
      step();
      chk("tbl_valid", 32'(if_a.RdData_Valid), 32'(tbl[k].ev));
      chk("tbl_err",   32'(if_a.Err),          32'(tbl[k].ee));
      chk("tbl_data",  32'(if_a.RdData),       32'(tbl[k].ed));
`ifdef REG_FILE_SHADOW_EN
      chk("tbl_reg0",  32'(regout_a[7:0]),     32'(tbl[k].r0_shadow));
`else
      chk("tbl_reg0",  32'(regout_a[7:0]),     32'(tbl[k].r0_plain));
`endif
    end
    set_in(0, 0, '0, '0, 0);
    step();

    // Back-to-back reads on the RD_LAT=2 instance: one Valid per read, no bubbles.
    bb_d[0] = 8'h81; bb_d[1] = 8'hA5; bb_d[2] = 8'h22; bb_d[3] = 8'h77;
    for (int k = 0; k < 4; k++) begin
      set_in(0, 1, (k == 0) ? 4'd2 : (k == 1) ? 4'd5 : (k == 2) ? 4'd0 : 4'd13, '0, 0);
      step();
      if (k >= 1) begin
        chk("bb_valid", 32'(if_b.RdData_Valid), 32'd1);
        chk("bb_data",  32'(if_b.RdData),       32'(bb_d[k-1]));
      end
    end
    set_in(0, 0, '0, '0, 0);
    step();
    chk("bb_valid_last", 32'(if_b.RdData_Valid), 32'd1);
    chk("bb_data_last",  32'(if_b.RdData),       32'h77);
    step();
    chk("bb_drained", 32'(if_b.RdData_Valid), 32'd0);
    chk("bb_held",    32'(if_b.RdData),       32'h77);

    // Reset while the RD_LAT=2 read is still in flight: it must be dropped.
    set_in(0, 1, 4'd3, '0, 0);
    step();
    do_reset(2);
    set_in(0, 0, '0, '0, 0);
    step();
    chk("rst_drop_valid", 32'(if_b.RdData_Valid), 32'd0);
    chk("rst_drop_data",  32'(if_b.RdData),       32'd0);

    rst_d[0] = 8'h00; rst_d[1] = 8'h00; rst_d[2] = 8'h81; rst_d[3] = 8'h20;
    for (int k = 0; k < 4; k++) begin
      set_in(0, 1, AW'(k), '0, 0);
      step();
      chk("def_a_valid", 32'(if_a.RdData_Valid), 32'd1);
      chk("def_a_data",  32'(if_a.RdData),       32'(rst_d[k]));
      chk("def_a_err",   32'(if_a.Err),          32'd0);
      if (k >= 1) chk("def_b_data", 32'(if_b.RdData), 32'(rst_d[k-1]));
    end
    set_in(0, 0, '0, '0, 0);
    step();
    chk("def_b_last", 32'(if_b.RdData), 32'h20);
    chk("def_a_idle", 32'(if_a.RdData_Valid), 32'd0);

    // Randomised traffic against the model, with one reset in the middle.
    for (int n = 0; n < 1000; n++) begin
      if (n == 500) do_reset(1);
      set_in($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
             AW'($urandom_range(0, 15)), DW'($urandom), $urandom_range(0, 7) == 0);
      step();
    end
    set_in(0, 0, '0, '0, 0);
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
